cla_seq_addsub: RTL and testbench
=================================

// Module: cla_seq_addsub
// PURPOSE
//  Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit carry-lookahead slice per cycle.
//  Subtraction is the inverse direction of the 4-bit CLA adder: a - b = a + ~b + 1.
//  Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
//  Trades latency (WIDTH/4 cycles) for a single CLA slice in area.
// PARAMETERS
//  WIDTH   16   operand/result width; must be a multiple of 4 and >= 4
// PORTS
//  clk        in   1      rising-edge clock; the only clock in the block
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand request valid
//  in_ready   out  1      block can accept an operand request
//  a          in   WIDTH  operand A (unsigned or two's complement)
//  b          in   WIDTH  operand B
//  sub        in   1      0: a+b; 1: a-b
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts the result
//  result     out  WIDTH  sum or difference, modulo 2^WIDTH
//  carry      out  1      carry-out of the MSB slice; in sub mode, carry=1 means no borrow
//  overflow   out  1      signed overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//  FSM states: IDLE, RUN, DONE. Reset state is IDLE.
//  Reset values: in_ready=1, out_valid=0, result=0, carry=0, overflow=0, slice counter=0.
//  IDLE: in_ready=1. When in_valid&in_ready:
//   - latch a into the A register and (sub ? ~b : b) into the B register;
//   - set the running carry to sub;
//   - go to RUN with the slice index at 0.
//  RUN: in_ready=0. Each cycle:
//   - feed nibble[idx] of A/B plus the running carry to the CLA slice;
//   - write the slice sum into result nibble[idx] and register the slice carry-out;
//   - idx increments by 1.
//  On the last nibble (idx = WIDTH/4-1):
//   - capture carry and overflow (uses the slice's c[2] and c[3]);
//   - go to DONE.
//  Latency: out_valid rises exactly WIDTH/4 cycles after the accept edge (4 cycles at WIDTH=16).
//  DONE: out_valid=1. result, carry and overflow are held stable while out_ready=0.
//   out_valid&out_ready returns the FSM to IDLE (out_valid=0, in_ready=1) on the next cycle.
//   No input is accepted in that same cycle, so the throughput is one operation per WIDTH/4+2 cycles.
//  in_valid while busy (RUN/DONE) is ignored; the operands are not sampled.
//  Index wrap: idx returns to 0 when leaving RUN; it never exceeds WIDTH/4-1.
//  rst_n asserted mid-RUN or mid-DONE: the operation is abandoned immediately.
//   All outputs return to their reset values. No partial result is ever presented.
//  WIDTH=4 degenerates to a single RUN cycle.
// STRUCTURE
//  Shared package cla_pkg:
//   - FSM state typedef (IDLE/RUN/DONE);
//   - localparam SLICE_W=4;
//   - function nslices(WIDTH) = WIDTH/SLICE_W.
//  One sub-module, cla4_slice: combinational 4-bit CLA.
//   - inputs a[3:0], b[3:0], cin;
//   - outputs s[3:0], c[3:0] (per-bit carries, c[3]=carry-out).
//  Top level holds the FSM, operand/result registers, slice counter and running carry.
// TESTING (WIDTH=16)
//  1 add 0x0006+0x0002 -> result=0x0008, carry=0, overflow=0; out_valid 4 cycles after accept.
//  2 sub 0x0003-0x000A -> result=0xFFF9, carry=0 (borrow), overflow=0.
//  3 add 0xFFFF+0x0001 -> result=0x0000, carry=1, overflow=0; sub 0x8000-0x0001 -> 0x7FFF, carry=1, overflow=1.
//  4 backpressure: out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0,
//    in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
//  5 rst_n low for 1 cycle at RUN idx=2 -> out_valid=0, in_ready=1 immediately;
//    the next request 0x1234+0x1111 -> 0x2345.
//  6 random sweep of 1000 ops with random in_valid/out_ready -> every result matches a model of a±b mod 2^16 plus its flags.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder/subtractor:
// FSM state encoding, slice width and the slice-count helper.
package cla_pkg;

    // Operation sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the single carry-lookahead slice reused every cycle
    localparam int SLICE_W = 4;

    // Number of slice passes needed to cover a WIDTH-bit operand
    function automatic int nslices(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice. c[i] is the carry out of bit i,
// so c[3] is the slice carry-out and c[2] is the carry into the top bit.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic [3:0] c
);

    logic [3:0] g;
    logic [3:0] p;

    assign g = a & b;
    assign p = a ^ b;

    // All four carries are flattened sums of generate/propagate terms so no
    // carry ripples through another carry.
    assign c[0] = g[0]
                | (p[0] & cin);
    assign c[1] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[2] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[3] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    // Each sum bit is its propagate term XOR the carry coming into that bit
    assign s = p ^ {c[2:0], cin};

endmodule

// File: rtl/cla_seq_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor. One 4-bit CLA slice is reused once
// per nibble, least significant nibble first; subtraction is a + ~b + 1.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer side accepts only in IDLE; the result side holds
// out_valid, result, carry and overflow stable until out_ready is seen.
module cla_seq_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int NS    = nslices(WIDTH);
    localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NS - 1);

    // Sequencer state, kept as a plain named register so checkers can bind to it
    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [IDX_W-1:0] idx;
    logic             run_c;
    logic             carry_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [SLICE_W-1:0] a_nib;
    logic [SLICE_W-1:0] b_nib;
    logic [SLICE_W-1:0] s_nib;
    logic [SLICE_W-1:0] c_nib;

    // Lower slice carries are internal to the slice and not needed here
    logic unused_low_carries;
    assign unused_low_carries = ^c_nib[1:0];

    // Select the operand nibbles addressed by the slice counter
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < NS; k++) begin
            if (idx == IDX_W'(k)) begin
                a_nib = a_q[k*SLICE_W +: SLICE_W];
                b_nib = b_q[k*SLICE_W +: SLICE_W];
            end
        end
    end

    cla4_slice u_slice (
        .a   (a_nib),
        .b   (b_nib),
        .cin (run_c),
        .s   (s_nib),
        .c   (c_nib)
    );

    // Sequencer: accept operands, run one nibble per cycle, hold the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            idx         <= '0;
            run_c       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        // Subtraction inverts B here; the +1 enters as the first carry
                        b_q        <= sub ? ~b : b;
                        run_c      <= sub;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NS; k++) begin
                        if (idx == IDX_W'(k)) begin
                            res_q[k*SLICE_W +: SLICE_W] <= s_nib;
                        end
                    end
                    run_c <= c_nib[3];
                    if (idx == LAST_IDX) begin
                        carry_q     <= c_nib[3];
                        // Signed overflow: carry into MSB differs from carry out of MSB
                        ovf_q       <= c_nib[3] ^ c_nib[2];
                        out_valid_q <= 1'b1;
                        idx         <= '0;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    idx         <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_cla_seq_addsub.sv
// Bench for cla_seq_addsub at WIDTH=16: directed vectors with literal
// expectations, a reference model of a +/- b with flags, and a per-cycle
// compare of every presented result against the model queue.
`timescale 1ns/1ps
module tb_cla_seq_addsub;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    logic [W+1:0] exp_q[$];
    int cyc     = 0;
    int acc_cyc = 0;
    int n_acc   = 0;
    int n_done  = 0;
    logic prev_ov = 1'b0;
    logic stop_consumer = 1'b0;

    cla_seq_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: {result, carry, overflow} from plain arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic ms);
        logic [W:0]   wide;
        logic [W-1:0] r;
        logic         c;
        logic         o;
        if (!ms) begin
            wide = {1'b0, ma} + {1'b0, mb};
            r = wide[W-1:0];
            c = wide[W];
            o = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
        end else begin
            r = ma - mb;
            c = (ma >= mb);
            o = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
        end
        return {r, c, o};
    endfunction

    // Scoreboard bookkeeping on handshake edges; reset abandons the pending op
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            cyc++;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n_done++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub));
                acc_cyc = cyc;
                n_acc++;
            end
        end
    end

    // Per-cycle compare of presented results against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("model_result", 32'(result), 32'(exp_q[0][W+1:2]));
                    chk("model_carry", 32'(carry), 32'(exp_q[0][1]));
                    chk("model_overflow", 32'(overflow), 32'(exp_q[0][0]));
                end
                chk("busy_in_ready", 32'(in_ready), 32'd0);
                if (!prev_ov) chk("latency", 32'(cyc - acc_cyc), 32'd4);
            end
            prev_ov = out_valid;
        end
    end

    // Driver: present one request and hold it until accepted
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
        int n;
        n = 0;
        @(negedge clk);
        a = ta;
        b = tb_v;
        sub = ts;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for a result, stall it for 'hold' cycles, then consume it
    task automatic wait_out(input int hold, output logic [W-1:0] r, output logic c,
                            output logic o, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
        r = result;
        c = carry;
        o = overflow;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_result", 32'(result), 32'(r));
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            a = 16'hFFFF;
            b = 16'hFFFF;
            sub = 1'b0;
            in_valid = h[0];
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    logic [W-1:0] r;
    logic         c;
    logic         o;
    int           lat;
    int           base_done;
    int           base_acc;
    int           drain;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_carry", 32'(carry), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        #2 rst_n = 1'b1;

        // 1: small add and latency
        send(16'h0006, 16'h0002, 1'b0);
        wait_out(0, r, c, o, lat);
        chk("t1_latency", 32'(lat), 32'd4);
        chk("t1_result", 32'(r), 32'h0008);
        chk("t1_carry", 32'(c), 32'd0);
        chk("t1_overflow", 32'(o), 32'd0);

        // 2: subtract with borrow
        send(16'h0003, 16'h000A, 1'b1);
        wait_out(0, r, c, o, lat);
        chk("t2_result", 32'(r), 32'hFFF9);
        chk("t2_carry", 32'(c), 32'd0);
        chk("t2_overflow", 32'(o), 32'd0);

        // 3: wrap-around add and signed-overflow subtract
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_out(0, r, c, o, lat);
        chk("t3a_result", 32'(r), 32'h0000);
        chk("t3a_carry", 32'(c), 32'd1);
        chk("t3a_overflow", 32'(o), 32'd0);
        send(16'h8000, 16'h0001, 1'b1);
        wait_out(0, r, c, o, lat);
        chk("t3b_result", 32'(r), 32'h7FFF);
        chk("t3b_carry", 32'(c), 32'd1);
        chk("t3b_overflow", 32'(o), 32'd1);

        // 4: backpressure for 5 cycles with ignored in_valid pulses
        send(16'h7FFF, 16'h0001, 1'b0);
        wait_out(5, r, c, o, lat);
        chk("t4_result", 32'(r), 32'h8000);
        chk("t4_carry", 32'(c), 32'd0);
        chk("t4_overflow", 32'(o), 32'd1);

        // 5: reset mid-RUN at nibble 2, then a fresh request
        send(16'h5555, 16'h2222, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t5_rst_result", 32'(result), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(16'h1234, 16'h1111, 1'b0);
        wait_out(0, r, c, o, lat);
        chk("t5_result", 32'(r), 32'h2345);
        chk("t5_carry", 32'(c), 32'd0);

        // 6: reset while a result is waiting in DONE
        send(16'hFFFF, 16'hFFFF, 1'b0);
        repeat (5) @(negedge clk);
        chk("t6_pre_out_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_result", 32'(result), 32'd0);
        chk("t6_rst_carry", 32'(carry), 32'd0);
        chk("t6_rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // 7: random sweep with random request gaps and consumer stalls
        base_done = n_done;
        base_acc = n_acc;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send(pick(), pick(), 1'($urandom_range(0, 1)));
                end
                drain = 0;
                while ((exp_q.size() != 0 || out_valid) && drain < 200) begin
                    @(negedge clk);
                    drain++;
                end
                chk("drain_empty", 32'(exp_q.size()), 32'd0);
                stop_consumer = 1'b1;
            end
            begin
                while (!stop_consumer) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b0;
            end
        join
        chk("sweep_accepted", 32'(n_acc - base_acc), 32'd1000);
        chk("sweep_completed", 32'(n_done - base_done), 32'd1000);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
